// File: rtl/hazard_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
// Optional feature macro: HAZARD_STALL_PERF_EN (see hazard_ctrl_pipe).
package hazard_pkg;

   localparam int PCSRC_PC4 = 0;
   localparam int PCSRC_BR  = 1;
   localparam int PCSRC_J   = 2;
   localparam int PCSRC_JR  = 3;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_MEM_WAIT = 2'd2
   } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_pipe_if.sv
// Hazard controller bus: decode/EX/MEM status in, pipeline enables/flushes out, plus debug view.
// Level semantics only: every input is sampled on each rising clk, every output is valid the same cycle.
interface hazard_ctrl_pipe_if
   import hazard_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int PCSRC_W = 3
);
   logic               ex_mem_read;
   logic [REG_AW-1:0]  ex_rt;
   logic [REG_AW-1:0]  id_rs;
   logic [REG_AW-1:0]  id_rt;
   logic               id_uses_rt;
   logic [PCSRC_W-1:0] pc_src;
   logic               mem_req;
   logic               mem_ready;
   logic               pc_write;
   logic               ifd_write;
   logic               ifd_flush;
   logic               idex_flush;
   logic               exmem_write;
   logic [31:0]        stall_cycles;
   hz_state_e          dbg_state;
   logic [2:0]         dbg_lu_cnt;

   modport master (
      output ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt, pc_src, mem_req, mem_ready,
      input  pc_write, ifd_write, ifd_flush, idex_flush, exmem_write, stall_cycles,
             dbg_state, dbg_lu_cnt
   );

   modport slave (
      input  ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt, pc_src, mem_req, mem_ready,
      output pc_write, ifd_write, ifd_flush, idex_flush, exmem_write, stall_cycles,
             dbg_state, dbg_lu_cnt
   );
endinterface

// File: rtl/hazard_lu_detect.sv
// Combinational load-use hazard comparator; register $0 never produces a hazard.
module hazard_lu_detect #(
   parameter int REG_AW = 5
) (
   input  logic              ex_mem_read_i,
   input  logic [REG_AW-1:0] ex_rt_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              id_uses_rt_i,
   output logic              lu_hit_o
);
   logic rs_match;
   logic rt_match;

   assign rs_match = (ex_rt_i == id_rs_i);
   assign rt_match = id_uses_rt_i & (ex_rt_i == id_rt_i);
   assign lu_hit_o = ex_mem_read_i & (ex_rt_i != '0) & (rs_match | rt_match);
endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Pipeline hazard controller: multi-cycle load-use stalls, data-memory wait, redirect flushes.
// Define HAZARD_STALL_PERF_EN to build the 32-bit stall-cycle counter; otherwise stall_cycles reads 0.
module hazard_ctrl_pipe
   import hazard_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int PCSRC_W     = 3,
   parameter int LOAD_LAT    = 1,
   parameter int FLUSH_DEPTH = 1
) (
   input logic               clk,
   input logic               reset,
   hazard_ctrl_pipe_if.slave hz
);
   localparam logic FLUSH2 = (FLUSH_DEPTH == 2);

   hz_state_e  state_q, state_d;
   logic [2:0] lu_cnt_q, lu_cnt_d;
   logic       pend_redir_q, pend_redir_d;
   logic       pend_flush2_q, pend_flush2_d;

   logic lu_hit;
   logic redir;
   logic mem_wait;
   logic pc_write_c, ifd_write_c, ifd_flush_c, idex_flush_c, exmem_write_c;

   hazard_lu_detect #(.REG_AW(REG_AW)) u_lu_detect (
      .ex_mem_read_i (hz.ex_mem_read),
      .ex_rt_i       (hz.ex_rt),
      .id_rs_i       (hz.id_rs),
      .id_rt_i       (hz.id_rt),
      .id_uses_rt_i  (hz.id_uses_rt),
      .lu_hit_o      (lu_hit)
   );

   assign redir = (hz.pc_src == PCSRC_W'(PCSRC_BR)) |
                  (hz.pc_src == PCSRC_W'(PCSRC_J))  |
                  (hz.pc_src == PCSRC_W'(PCSRC_JR));
   assign mem_wait = hz.mem_req & ~hz.mem_ready;

   always_comb begin
      state_d       = state_q;
      lu_cnt_d      = lu_cnt_q;
      pend_redir_d  = pend_redir_q;
      pend_flush2_d = pend_flush2_q;
      pc_write_c    = 1'b1;
      ifd_write_c   = 1'b1;
      ifd_flush_c   = 1'b0;
      idex_flush_c  = 1'b0;
      exmem_write_c = 1'b1;

      if (mem_wait) begin
         // Whole pipe frozen; a redirect arriving now is remembered for the release cycle.
         pc_write_c    = 1'b0;
         ifd_write_c   = 1'b0;
         exmem_write_c = 1'b0;
         state_d       = ST_MEM_WAIT;
         if (redir) begin
            pend_redir_d  = 1'b1;
            pend_flush2_d = FLUSH2;
         end
      end else if (state_q == ST_LU_STALL || (state_q == ST_MEM_WAIT && lu_cnt_q != 3'd0)) begin
         pc_write_c   = 1'b0;
         ifd_write_c  = 1'b0;
         idex_flush_c = 1'b1;
         lu_cnt_d     = lu_cnt_q - 3'd1;
         state_d      = (lu_cnt_q == 3'd1) ? ST_RUN : ST_LU_STALL;
      end else begin
         state_d = ST_RUN;
         if (lu_hit) begin
            pc_write_c   = 1'b0;
            ifd_write_c  = 1'b0;
            idex_flush_c = 1'b1;
            if (LOAD_LAT > 1) begin
               lu_cnt_d = 3'(LOAD_LAT - 1);
               state_d  = ST_LU_STALL;
            end
         end else if (redir || pend_redir_q) begin
            ifd_flush_c   = 1'b1;
            idex_flush_c  = FLUSH2 | (pend_redir_q & pend_flush2_q);
            pend_redir_d  = 1'b0;
            pend_flush2_d = 1'b0;
         end
      end

      // Reset drives the pipeline into a bubbled, frozen state regardless of the FSM.
      if (!reset) begin
         pc_write_c    = 1'b0;
         ifd_write_c   = 1'b0;
         ifd_flush_c   = 1'b1;
         idex_flush_c  = 1'b1;
         exmem_write_c = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_RUN;
         lu_cnt_q      <= 3'd0;
         pend_redir_q  <= 1'b0;
         pend_flush2_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         lu_cnt_q      <= lu_cnt_d;
         pend_redir_q  <= pend_redir_d;
         pend_flush2_q <= pend_flush2_d;
      end
   end

   assign hz.pc_write    = pc_write_c;
   assign hz.ifd_write   = ifd_write_c;
   assign hz.ifd_flush   = ifd_flush_c;
   assign hz.idex_flush  = idex_flush_c;
   assign hz.exmem_write = exmem_write_c;
   assign hz.dbg_state   = state_q;
   assign hz.dbg_lu_cnt  = lu_cnt_q;

`ifdef HAZARD_STALL_PERF_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= 32'd0;
      end else if (!pc_write_c) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign hz.stall_cycles = stall_cnt_q;
`else
   assign hz.stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Bench for hazard_ctrl_pipe: dut_a (LOAD_LAT=1, FLUSH_DEPTH=1) and dut_b (LOAD_LAT=3, FLUSH_DEPTH=2).
module tb_hazard_ctrl_pipe;
   import hazard_pkg::*;

   // Output bundle order: {pc_write, ifd_write, ifd_flush, idex_flush, exmem_write}
   localparam logic [4:0] O_RUN   = 5'b11001;
   localparam logic [4:0] O_STALL = 5'b00011;
   localparam logic [4:0] O_RD1   = 5'b11101;
   localparam logic [4:0] O_RD2   = 5'b11111;
   localparam logic [4:0] O_FRZ   = 5'b00000;
   localparam logic [4:0] O_RST   = 5'b00110;

   typedef struct {
      logic       mr;
      logic [4:0] ert;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urt;
      logic [2:0] pcs;
      logic       mq;
      logic       mrdy;
      logic [4:0] exp;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   hazard_ctrl_pipe_if #(.REG_AW(5), .PCSRC_W(3)) ifa ();
   hazard_ctrl_pipe_if #(.REG_AW(5), .PCSRC_W(3)) ifb ();

   hazard_ctrl_pipe #(.REG_AW(5), .PCSRC_W(3), .LOAD_LAT(1), .FLUSH_DEPTH(1)) dut_a (
      .clk   (clk),
      .reset (reset),
      .hz    (ifa.slave)
   );

   hazard_ctrl_pipe #(.REG_AW(5), .PCSRC_W(3), .LOAD_LAT(3), .FLUSH_DEPTH(2)) dut_b (
      .clk   (clk),
      .reset (reset),
      .hz    (ifb.slave)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks
   task automatic set_in(input bit sel, input logic mr, input logic [4:0] ert,
                         input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic [2:0] pcs, input logic mq, input logic mrdy);
      if (!sel) begin
         ifa.ex_mem_read = mr; ifa.ex_rt = ert; ifa.id_rs = rs; ifa.id_rt = rt;
         ifa.id_uses_rt = urt; ifa.pc_src = pcs; ifa.mem_req = mq; ifa.mem_ready = mrdy;
      end else begin
         ifb.ex_mem_read = mr; ifb.ex_rt = ert; ifb.id_rs = rs; ifb.id_rt = rt;
         ifb.id_uses_rt = urt; ifb.pc_src = pcs; ifb.mem_req = mq; ifb.mem_ready = mrdy;
      end
   endtask

   task automatic idle(input bit sel);
      set_in(sel, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
   endtask

   task automatic cycle_start;
      @(negedge clk);
   endtask

   function automatic logic [4:0] outs(input bit sel);
      if (!sel)
         return {ifa.pc_write, ifa.ifd_write, ifa.ifd_flush, ifa.idex_flush, ifa.exmem_write};
      return {ifb.pc_write, ifb.ifd_write, ifb.ifd_flush, ifb.idex_flush, ifb.exmem_write};
   endfunction

   // Scoreboard
   task automatic check_o(input string name, input bit sel, input logic [4:0] exp);
      logic [4:0] act;
      act = outs(sel);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: outputs got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   vec_t tbl[15];

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      idle(0);
      idle(1);

      tbl[0]  = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 3'd0, 1'b0, 1'b0, O_RUN};
      tbl[1]  = '{1'b1, 5'd5,  5'd5,  5'd0, 1'b0, 3'd0, 1'b0, 1'b0, O_STALL};
      tbl[2]  = '{1'b1, 5'd5,  5'd1,  5'd5, 1'b1, 3'd0, 1'b0, 1'b0, O_STALL};
      tbl[3]  = '{1'b1, 5'd5,  5'd1,  5'd5, 1'b0, 3'd0, 1'b0, 1'b0, O_RUN};
      tbl[4]  = '{1'b1, 5'd0,  5'd0,  5'd0, 1'b1, 3'd0, 1'b0, 1'b0, O_RUN};
      tbl[5]  = '{1'b0, 5'd5,  5'd5,  5'd5, 1'b1, 3'd0, 1'b0, 1'b0, O_RUN};
      tbl[6]  = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 3'd2, 1'b0, 1'b0, O_RD1};
      tbl[7]  = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 3'd1, 1'b0, 1'b0, O_RD1};
      tbl[8]  = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 3'd3, 1'b0, 1'b0, O_RD1};
      tbl[9]  = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 3'd4, 1'b0, 1'b0, O_RUN};
      tbl[10] = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 3'd7, 1'b0, 1'b0, O_RUN};
      tbl[11] = '{1'b1, 5'd5,  5'd5,  5'd0, 1'b0, 3'd3, 1'b0, 1'b0, O_STALL};
      tbl[12] = '{1'b1, 5'd5,  5'd5,  5'd0, 1'b0, 3'd0, 1'b1, 1'b1, O_STALL};
      tbl[13] = '{1'b1, 5'd31, 5'd31, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, O_STALL};
      tbl[14] = '{1'b1, 5'd7,  5'd6,  5'd8, 1'b1, 3'd0, 1'b0, 1'b0, O_RUN};

      // Reset state
      cycle_start();
      cycle_start();
      #1;
      check_o("reset_a", 0, O_RST);
      check_o("reset_b", 1, O_RST);
      check_v("reset_state_b", 32'(ifb.dbg_state), 32'(ST_RUN));
      check_v("reset_cnt_b", 32'(ifb.dbg_lu_cnt), 32'd0);
      check_v("stall_cycles_reset", ifa.stall_cycles, 32'd0);
      cycle_start();
      reset = 1'b1;
      #1;
      check_o("post_reset_a", 0, O_RUN);

      // Table-driven single-cycle vectors on dut_a (stays in RUN throughout)
      for (int i = 0; i < 15; i++) begin
         cycle_start();
         set_in(0, tbl[i].mr, tbl[i].ert, tbl[i].rs, tbl[i].rt, tbl[i].urt,
                tbl[i].pcs, tbl[i].mq, tbl[i].mrdy);
         #1;
         check_o($sformatf("vec%0d", i), 0, tbl[i].exp);
      end
      cycle_start();
      idle(0);
      #1;
      check_o("a_after_table", 0, O_RUN);
      check_v("a_state_run", 32'(ifa.dbg_state), 32'(ST_RUN));

      // LOAD_LAT=3: one hazard cycle yields exactly three bubbles
      cycle_start();
      set_in(1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 3'd0, 1'b0, 1'b0);
      #1;
      check_o("b_lu_1", 1, O_STALL);
      for (int k = 2; k <= 3; k++) begin
         cycle_start();
         idle(1);
         #1;
         check_o($sformatf("b_lu_%0d", k), 1, O_STALL);
         check_v($sformatf("b_lu_state_%0d", k), 32'(ifb.dbg_state), 32'(ST_LU_STALL));
      end
      cycle_start();
      #1;
      check_o("b_lu_done", 1, O_RUN);

      // Load to $0 never stalls
      cycle_start();
      set_in(1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0);
      #1;
      check_o("b_lu_r0", 1, O_RUN);
      cycle_start();
      idle(1);
      #1;
      check_v("b_lu_r0_state", 32'(ifb.dbg_state), 32'(ST_RUN));

      // FLUSH_DEPTH=2 flushes both IF/ID and ID/EX
      cycle_start();
      set_in(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd2, 1'b0, 1'b0);
      #1;
      check_o("b_jump_fd2", 1, O_RD2);
      cycle_start();
      set_in(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd4, 1'b0, 1'b0);
      #1;
      check_o("b_pcsrc4", 1, O_RUN);

      // Memory wait with branch held: frozen 4 cycles, flush on the ready cycle
      for (int k = 1; k <= 4; k++) begin
         cycle_start();
         set_in(0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd1, 1'b1, 1'b0);
         #1;
         check_o($sformatf("a_memwait_%0d", k), 0, O_FRZ);
      end
      check_v("a_memwait_state", 32'(ifa.dbg_state), 32'(ST_MEM_WAIT));
      cycle_start();
      set_in(0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd1, 1'b1, 1'b1);
      #1;
      check_o("a_mem_ready_flush", 0, O_RD1);
      cycle_start();
      idle(0);
      #1;
      check_o("a_mem_after", 0, O_RUN);

      // Redirect seen only while waiting is applied from the pending latch
      cycle_start();
      set_in(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd3, 1'b1, 1'b0);
      #1;
      check_o("b_pend_wait1", 1, O_FRZ);
      cycle_start();
      set_in(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      #1;
      check_o("b_pend_wait2", 1, O_FRZ);
      cycle_start();
      set_in(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b1, 1'b1);
      #1;
      check_o("b_pend_apply", 1, O_RD2);
      cycle_start();
      idle(1);
      #1;
      check_o("b_pend_cleared", 1, O_RUN);

      // Load-use and jr together: stall wins, redirect taken once the stall ends
      cycle_start();
      set_in(1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 3'd3, 1'b0, 1'b0);
      #1;
      check_o("b_lu_jr_1", 1, O_STALL);
      for (int k = 2; k <= 3; k++) begin
         cycle_start();
         set_in(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd3, 1'b0, 1'b0);
         #1;
         check_o($sformatf("b_lu_jr_%0d", k), 1, O_STALL);
      end
      cycle_start();
      #1;
      check_o("b_lu_jr_redirect", 1, O_RD2);
      cycle_start();
      idle(1);

      // Reset asserted in the middle of LU_STALL
      cycle_start();
      set_in(1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
      #1;
      check_o("b_rst_mid_1", 1, O_STALL);
      cycle_start();
      idle(1);
      #1;
      check_v("b_rst_mid_cnt_before", 32'(ifb.dbg_lu_cnt), 32'd2);
      #2;
      reset = 1'b0;
      #1;
      check_o("b_rst_mid_outs", 1, O_RST);
      check_v("b_rst_mid_state", 32'(ifb.dbg_state), 32'(ST_RUN));
      check_v("b_rst_mid_cnt", 32'(ifb.dbg_lu_cnt), 32'd0);
      cycle_start();
      reset = 1'b1;
      #1;
      check_o("b_rst_mid_release", 1, O_RUN);
      cycle_start();
      #1;
      check_o("b_rst_mid_run", 1, O_RUN);

`ifdef HAZARD_STALL_PERF_EN
      // Five stall cycles on dut_a after a fresh reset
      cycle_start();
      reset = 1'b0;
      cycle_start();
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle_start();
         set_in(0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
      end
      cycle_start();
      idle(0);
      #1;
      check_v("perf_five", ifa.stall_cycles, 32'd5);
      cycle_start();
      dut_a.stall_cnt_q = 32'hFFFF_FFFF;
      set_in(0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
      cycle_start();
      idle(0);
      #1;
      check_v("perf_wrap", ifa.stall_cycles, 32'd0);
`else
      check_v("perf_tied_a", ifa.stall_cycles, 32'd0);
      check_v("perf_tied_b", ifb.stall_cycles, 32'd0);
`endif

      // Final report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running expected done");
      $fatal(1, "timeout");
   end
endmodule
